data_mem_resp: RTL and testbench

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_lane_align.sv | 56 +++++
 rtl/data_mem_resp.sv | 138 +++++++++++++
 tb/tb_data_mem_resp.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared access-size encodings, FSM state type and memory
//                geometry for the data memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam logic [1:0]  MODE_B = 2'b00;
    localparam logic [1:0]  MODE_H = 2'b01;
    localparam logic [1:0]  MODE_W = 2'b10;
    localparam logic [1:0]  MODE_R = 2'b11;

    localparam logic [11:0] LED_ADDR_DEFAULT = 12'hFFC;
    localparam int          RAM_DEPTH        = 1024;
    localparam int          RAM_AW           = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_align
//  Description : Combinational byte-lane steering: write enables, replicated
//                write data, zero-extended read extraction, alignment check.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  mode,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    always_comb begin
        be         = 4'b0000;
        wdata_lane = wdata;
        rdata_ext  = 32'd0;
        misalign   = 1'b0;
        case (mode)
            MODE_B: begin
                // Replicating the byte lets the enables alone pick the lane.
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                case (addr_lo)
                    2'd0:    rdata_ext = {24'd0, rword[7:0]};
                    2'd1:    rdata_ext = {24'd0, rword[15:8]};
                    2'd2:    rdata_ext = {24'd0, rword[23:16]};
                    default: rdata_ext = {24'd0, rword[31:24]};
                endcase
            end
            MODE_H: begin
                misalign   = addr_lo[0];
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {16'd0, (addr_lo[1] ? rword[31:16] : rword[15:0])};
            end
            MODE_W: begin
                misalign   = (addr_lo != 2'b00);
                be         = 4'b1111;
                rdata_ext  = rword;
            end
            default: begin
                misalign   = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_resp.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_resp
//  Description : 1K x 32 data memory with wait-state response FSM and a
//                memory-mapped LED register.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_resp
    import mem_pkg::*;
#(
    parameter int          WAIT     = 1,
    parameter logic [11:0] LED_ADDR = LED_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  mode,
    input  logic [11:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] leddata
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  mode_q, mode_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] led_q, led_d;

    logic [31:0]       mem [RAM_DEPTH];
    logic [31:0]       rword_q;
    logic [RAM_AW-1:0] rd_idx;

    logic        is_led;
    logic [31:0] rword_src;
    logic [3:0]  be;
    logic [31:0] wdata_lane;
    logic [31:0] rdata_ext;
    logic        misalign;
    logic        access_err;
    logic        commit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    mode_d  = mode;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = 4'd0;
                    state_d = (WAIT > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == WAIT_LAST) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign is_led    = (addr_q == LED_ADDR);
    assign rword_src = is_led ? led_q : rword_q;

    mem_lane_align u_lane_align (
        .mode       (mode_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .rword      (rword_src),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext),
        .misalign   (misalign)
    );

    // The LED register only answers full-word accesses.
    assign access_err = misalign | (is_led & (mode_q != MODE_W));
    assign ready      = (state_q == ST_RESP);
    assign err        = ready & access_err;
    assign rdata      = (ready & ~we_q & ~access_err) ? rdata_ext : 32'd0;
    assign commit     = ready & we_q & ~access_err;
    assign led_d      = (commit & is_led) ? wdata_lane : led_q;
    assign leddata    = led_q;

    // Reading the bus address while idle makes the word ready at the accept
    // edge, so a zero-wait response still sees fresh data.
    assign rd_idx = (state_q == ST_IDLE) ? addr[11:2] : addr_q[11:2];

    always_ff @(posedge clk) begin
        rword_q <= mem[rd_idx];
        if (commit && !is_led) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr_q[11:2]][8*i +: 8] <= wdata_lane[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            mode_q  <= MODE_B;
            addr_q  <= 12'd0;
            wdata_q <= 32'd0;
            led_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            led_q   <= led_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_resp
//  Description : Randomized self-checking bench for data_mem_resp against a
//                word-array reference model; second instance runs zero-wait.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_resp;

    localparam int          TB_WAIT = 1;
    localparam logic [11:0] LED_A   = 12'hFFC;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [11:0] addr = 12'd0;
    logic [31:0] wdata = 32'd0;
    logic        ready, err;
    logic [31:0] rdata, leddata;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [1:0]  mode0 = 2'b00;
    logic [11:0] addr0 = 12'd0;
    logic [31:0] wdata0 = 32'd0;
    logic        ready0, err0;
    logic [31:0] rdata0, leddata0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m [1024];
    logic [31:0] led_m = 32'd0;

    always #5 clk = ~clk;

    data_mem_resp #(.WAIT(TB_WAIT), .LED_ADDR(LED_A)) dut (
        .clk(clk), .clr(clr), .req(req), .we(we), .mode(mode), .addr(addr),
        .wdata(wdata), .ready(ready), .rdata(rdata), .err(err), .leddata(leddata)
    );

    data_mem_resp #(.WAIT(0), .LED_ADDR(LED_A)) dut0 (
        .clk(clk), .clr(clr), .req(req0), .we(we0), .mode(mode0), .addr(addr0),
        .wdata(wdata0), .ready(ready0), .rdata(rdata0), .err(err0), .leddata(leddata0)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic model_err(input logic [1:0] md, input logic [11:0] a);
        return (md == 2'b11) || (md == 2'b01 && a[0]) || (md == 2'b10 && a[1:0] != 2'b00)
               || (a == LED_A && md != 2'b10);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] md, input logic [11:0] a);
        logic [31:0] word;
        if (model_err(md, a)) return 32'd0;
        word = (a == LED_A) ? led_m : m[a[11:2]];
        case (md)
            2'b00:   return (word >> (int'(a[1:0]) * 8)) & 32'hFF;
            2'b01:   return (word >> (int'(a[1]) * 16)) & 32'hFFFF;
            default: return word;
        endcase
    endfunction

    task automatic model_store(input logic [1:0] md, input logic [11:0] a, input logic [31:0] wd);
        int          sh;
        logic [31:0] mask;
        if (model_err(md, a)) return;
        if (a == LED_A) begin
            led_m = wd;
            return;
        end
        sh   = (md == 2'b00) ? int'(a[1:0]) * 8 : (md == 2'b01) ? int'(a[1]) * 16 : 0;
        mask = (md == 2'b00) ? (32'hFF << sh) : (md == 2'b01) ? (32'hFFFF << sh) : 32'hFFFF_FFFF;
        m[a[11:2]] = (m[a[11:2]] & ~mask) | ((wd << sh) & mask);
    endtask

    // Starts at a falling edge with the DUT idle; ends at the falling edge
    // one cycle after the response.
    task automatic txn(input logic w, input logic [1:0] md, input logic [11:0] a,
                       input logic [31:0] wd, output logic [31:0] rd_o, output logic err_o);
        logic        e_err;
        logic [31:0] e_rd;
        int          n;
        logic        got;
        e_err = model_err(md, a);
        e_rd  = w ? 32'd0 : model_load(md, a);
        req = 1'b1; we = w; mode = md; addr = a; wdata = wd;
        @(posedge clk); #1;
        req   = 1'($urandom_range(0, 1));
        we    = 1'($urandom_range(0, 1));
        mode  = 2'($urandom_range(0, 3));
        addr  = 12'($urandom);
        wdata = $urandom;
        n = 0; got = 1'b0; rd_o = 32'd0; err_o = 1'b0;
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            if (ready) got = 1'b1;
        end
        req = 1'b0;
        check_eq("latency", 64'(n), 64'(TB_WAIT + 1));
        if (got) begin
            rd_o  = rdata;
            err_o = err;
            check_eq("err", {63'd0, err}, {63'd0, e_err});
            if (!w) check_eq("rdata", {32'd0, rdata}, {32'd0, e_rd});
        end
        if (w) model_store(md, a, wd);
        @(negedge clk);
        check_eq("ready_pulse", {63'd0, ready}, 64'd0);
        check_eq("idle_outs", {31'd0, err, rdata}, 64'd0);
        check_eq("leddata", {32'd0, leddata}, {32'd0, led_m});
    endtask

    logic [31:0] rd, keep;
    logic        er;

    initial begin
        #2;
        check_eq("rst_ready", {63'd0, ready}, 64'd0);
        check_eq("rst_rdata", {32'd0, rdata}, 64'd0);
        check_eq("rst_err", {63'd0, err}, 64'd0);
        check_eq("rst_led", {32'd0, leddata}, 64'd0);
        check_eq("rst0_ready", {63'd0, ready0}, 64'd0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 64; i++) txn(1'b1, 2'b10, 12'(i * 4), $urandom, rd, er);

        txn(1'b1, 2'b10, 12'h010, 32'hDEADBEEF, rd, er);
        txn(1'b0, 2'b10, 12'h010, 32'h0, rd, er);
        check_eq("d_word", {32'd0, rd}, 64'hDEADBEEF);

        txn(1'b1, 2'b10, 12'h020, 32'h11223344, rd, er);
        txn(1'b1, 2'b00, 12'h022, 32'h000000AA, rd, er);
        txn(1'b0, 2'b10, 12'h020, 32'h0, rd, er);
        check_eq("d_bytemerge", {32'd0, rd}, 64'h11AA3344);
        txn(1'b0, 2'b01, 12'h022, 32'h0, rd, er);
        check_eq("d_half", {32'd0, rd}, 64'h000011AA);

        txn(1'b0, 2'b10, 12'h024, 32'h0, keep, er);
        txn(1'b0, 2'b01, 12'h021, 32'h0, rd, er);
        check_eq("d_mis_half", {31'd0, er, rd}, 64'h1_0000_0000);
        txn(1'b1, 2'b10, 12'h026, 32'hFFFFFFFF, rd, er);
        check_eq("d_mis_word_err", {63'd0, er}, 64'd1);
        txn(1'b0, 2'b10, 12'h024, 32'h0, rd, er);
        check_eq("d_unchanged", {32'd0, rd}, {32'd0, keep});

        txn(1'b1, 2'b10, LED_A, 32'h000000FF, rd, er);
        check_eq("d_led", {32'd0, leddata}, 64'hFF);
        txn(1'b1, 2'b00, LED_A, 32'h00000011, rd, er);
        check_eq("d_led_byte_err", {63'd0, er}, 64'd1);
        check_eq("d_led_kept", {32'd0, leddata}, 64'hFF);

        for (int i = 0; i < 150; i++) begin
            logic [11:0] a;
            a = ($urandom_range(0, 7) == 0) ? LED_A : 12'($urandom_range(0, 255));
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom, rd, er);
        end

        // Abort a store with reset while it sits in the wait state.
        txn(1'b1, 2'b10, 12'h030, 32'h12345678, rd, er);
        txn(1'b1, 2'b10, LED_A, 32'h0000A5A5, rd, er);
        req = 1'b1; we = 1'b1; mode = 2'b10; addr = 12'h030; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req = 1'b0;
        #2 clr = 1'b0;
        #1;
        check_eq("abort_ready", {63'd0, ready}, 64'd0);
        check_eq("abort_led", {32'd0, leddata}, 64'd0);
        check_eq("abort_outs", {31'd0, err, rdata}, 64'd0);
        @(negedge clk);
        clr   = 1'b1;
        led_m = 32'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("abort_noready", {63'd0, ready}, 64'd0);
        end
        txn(1'b0, 2'b10, 12'h030, 32'h0, rd, er);
        check_eq("abort_word", {32'd0, rd}, 64'h12345678);

        // Zero-wait instance with req held high; the bus shows a decoy store
        // during every response cycle.
        begin
            logic        tw [6];
            logic [11:0] ta [6];
            logic [31:0] td [6];
            logic [31:0] te [6];
            tw = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
            ta = '{12'h048, 12'h040, 12'h044, 12'h040, 12'h044, 12'h048};
            td = '{32'h0C0C0C0C, 32'hA1A2A3A4, 32'hB1B2B3B4, 32'h0, 32'h0, 32'h0};
            te = '{32'h0, 32'h0, 32'h0, 32'hA1A2A3A4, 32'hB1B2B3B4, 32'h0C0C0C0C};
            @(negedge clk);
            for (int k = 0; k < 6; k++) begin
                check_eq("z_idle", {63'd0, ready0}, 64'd0);
                req0 = 1'b1; we0 = tw[k]; mode0 = 2'b10; addr0 = ta[k]; wdata0 = td[k];
                @(negedge clk);
                check_eq("z_ready", {63'd0, ready0}, 64'd1);
                if (!tw[k]) check_eq("z_rdata", {32'd0, rdata0}, {32'd0, te[k]});
                we0 = 1'b1; addr0 = 12'h048; wdata0 = 32'hBAD0BAD0;
                @(negedge clk);
            end
            req0 = 1'b0;
            check_eq("z_end_idle", {63'd0, ready0}, 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
